// File: rtl/farm_sensor_conditioner_if.sv
// rtl/farm_sensor_conditioner_if.sv - farm-road sensor conditioner signal bundle
interface farm_sensor_conditioner_if #(
    parameter int CNT_W = 4
);
    logic             sensor_raw;
    logic [2:0]       light_farm;
    logic             C;
    logic             sensor_clean;
    logic [CNT_W-1:0] vehicle_count;
    logic             overflow;

    modport master (
        output sensor_raw,
        output light_farm,
        input  C,
        input  sensor_clean,
        input  vehicle_count,
        input  overflow
    );

    modport slave (
        input  sensor_raw,
        input  light_farm,
        output C,
        output sensor_clean,
        output vehicle_count,
        output overflow
    );
endinterface

// File: rtl/farm_sensor_conditioner.sv
// rtl/farm_sensor_conditioner.sv - farm-road loop sensor sync, debounce, queue count and request FSM
module farm_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int THRESH          = 2,
    parameter int MAX_WAIT        = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    farm_sensor_conditioner_if.slave      bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TM_W = $clog2(MAX_WAIT + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0]  TM_MAX  = TM_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITING,
        S_REQUEST,
        S_SERVED
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_clean;
    logic             r_clean_d;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_ovf;
    logic             w_ovf_next;
    logic [TM_W-1:0]  r_timer;
    logic [TM_W-1:0]  w_timer_inc;
    logic             r_c;
    logic             w_green;
    logic             w_red;
    logic             w_arrival;

    // Non-one-hot lamp codes match neither compare, so they count as "not green" and "not red".
    assign w_green   = (bus.light_farm == 3'b001);
    assign w_red     = (bus.light_farm == 3'b100);
    assign w_arrival = r_clean & ~r_clean_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
        end else begin
            r_sync1   <= bus.sensor_raw;
            r_sync2   <= r_sync1;
            r_clean_d <= r_clean;
            if (r_sync2 != r_clean) begin
                if (r_db_cnt == DB_LAST) begin
                    r_clean  <= ~r_clean;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        if (w_green) begin
            w_count_next = '0;
        end else if (w_arrival) begin
            if (r_count == CNT_MAX) begin
                w_ovf_next = 1'b1;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    assign w_timer_inc = (r_timer == TM_MAX) ? TM_MAX : r_timer + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = S_WAITING;
                end
            end
            S_WAITING: begin
                if ((r_count >= CNT_THR) || (w_timer_inc == TM_MAX)) begin
                    w_state_next = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (w_green) begin
                    w_state_next = S_SERVED;
                end
            end
            S_SERVED: begin
                // Vehicles that arrived during yellow keep the queue alive.
                if (w_red) begin
                    w_state_next = (r_count != '0) ? S_WAITING : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Timer sits at zero outside WAITING, so every entry starts a fresh wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_timer <= '0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_timer <= (r_state == S_WAITING) ? w_timer_inc : '0;
            r_c     <= (w_state_next == S_REQUEST);
        end
    end

    assign bus.C             = r_c;
    assign bus.sensor_clean  = r_clean;
    assign bus.vehicle_count = r_count;
    assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// tb/tb_farm_sensor_conditioner.sv - bench for farm_sensor_conditioner, two parameter sets side by side
module tb_farm_sensor_conditioner;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_REQ = 2, PH_SERVED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       raw = 1'b0;
    logic [2:0] light = 3'b100;
    int         n_err = 0;
    int         n_chk = 0;
    int         n_print = 0;

    always #5 clk = ~clk;

    farm_sensor_conditioner_if #(.CNT_W(4)) if_a ();
    farm_sensor_conditioner_if #(.CNT_W(2)) if_b ();

    assign if_a.sensor_raw = raw;
    assign if_a.light_farm = light;
    assign if_b.sensor_raw = raw;
    assign if_b.light_farm = light;

    farm_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .THRESH(1), .MAX_WAIT(20)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    farm_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(2), .THRESH(2), .MAX_WAIT(20)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    typedef struct {
        int s1, s2, clean, prev_clean, run, cnt, ovf, phase, age;
    } mdl_t;

    mdl_t m[2];
    int p_db[2]  = '{4, 4};
    int p_max[2] = '{15, 3};
    int p_thr[2] = '{1, 2};
    int p_mw[2]  = '{20, 20};

    typedef struct {
        logic       raw;
        logic [2:0] light;
        logic       clean;
        int         cnt;
        logic       c;
    } vec_t;

    function automatic logic [31:0] dut_val(int k, int f);
        if (k == 0) begin
            case (f)
                0: return 32'(if_a.sensor_clean);
                1: return 32'(if_a.vehicle_count);
                2: return 32'(if_a.C);
                default: return 32'(if_a.overflow);
            endcase
        end
        case (f)
            0: return 32'(if_b.sensor_clean);
            1: return 32'(if_b.vehicle_count);
            2: return 32'(if_b.C);
            default: return 32'(if_b.overflow);
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k] = '{0, 0, 0, 0, 0, 0, 0, PH_IDLE, 0};
        end
    endtask

    // One clock edge of the reference behaviour for instance k.
    task automatic model_step(int k);
        mdl_t o;
        mdl_t n;
        bit   green;
        bit   red;
        bit   arrival;
        o = m[k];
        n = o;
        green = (light == 3'b001);
        red   = (light == 3'b100);
        n.s1 = int'(raw);
        n.s2 = o.s1;
        n.prev_clean = o.clean;
        if (o.s2 != o.clean) begin
            n.run = o.run + 1;
            if (n.run == p_db[k]) begin
                n.clean = 1 - o.clean;
                n.run = 0;
            end
        end else begin
            n.run = 0;
        end
        arrival = (o.clean == 1) && (o.prev_clean == 0);
        if (green) n.cnt = 0;
        else if (arrival) begin
            if (o.cnt == p_max[k]) n.ovf = 1;
            else n.cnt = o.cnt + 1;
        end
        case (o.phase)
            PH_IDLE: if (n.cnt != 0) begin n.phase = PH_WAIT; n.age = 0; end
            PH_WAIT: begin
                n.age = o.age + 1;
                if (o.cnt >= p_thr[k] || n.age >= p_mw[k]) n.phase = PH_REQ;
            end
            PH_REQ: if (green) n.phase = PH_SERVED;
            default: if (red) begin
                n.phase = (o.cnt != 0) ? PH_WAIT : PH_IDLE;
                n.age = 0;
            end
        endcase
        m[k] = n;
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("model_clean[%0d]", k), dut_val(k, 0), 32'(m[k].clean));
            check($sformatf("model_count[%0d]", k), dut_val(k, 1), 32'(m[k].cnt));
            check($sformatf("model_C[%0d]", k), dut_val(k, 2), 32'(m[k].phase == PH_REQ));
            check($sformatf("model_ovf[%0d]", k), dut_val(k, 3), 32'(m[k].ovf));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_model();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_C[%0d]", k), dut_val(k, 2), 32'd0);
            check($sformatf("rst_clean[%0d]", k), dut_val(k, 0), 32'd0);
            check($sformatf("rst_count[%0d]", k), dut_val(k, 1), 32'd0);
            check($sformatf("rst_ovf[%0d]", k), dut_val(k, 3), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Full low-then-high cycle of the clean sensor, ending one edge after the rise.
    task automatic make_arrival();
        int guard;
        raw = 1'b0;
        guard = 0;
        while (m[0].clean == 1 && guard < 40) begin tick(); guard++; end
        check("arrival_fall_timeout", 32'(guard < 40), 32'd1);
        raw = 1'b1;
        guard = 0;
        while (m[0].clean == 0 && guard < 40) begin tick(); guard++; end
        check("arrival_rise_timeout", 32'(guard < 40), 32'd1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   guard;
        int   hold_raw;
        int   hold_light;
        logic [2:0] lights[6];

        tbl[0] = '{1'b1, 3'b100, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b1, 3'b100, 1'b0, 0, 1'b0};
        tbl[2] = '{1'b1, 3'b100, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b1, 3'b100, 1'b0, 0, 1'b0};
        tbl[4] = '{1'b1, 3'b100, 1'b0, 0, 1'b0};
        tbl[5] = '{1'b1, 3'b100, 1'b1, 0, 1'b0};
        tbl[6] = '{1'b1, 3'b100, 1'b1, 1, 1'b0};
        tbl[7] = '{1'b1, 3'b100, 1'b1, 1, 1'b1};
        tbl[8] = '{1'b1, 3'b100, 1'b1, 1, 1'b1};
        lights = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b011, 3'b000};

        #3;
        // Latency: raw high before edge 1.
        raw = 1'b1; light = 3'b100;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            raw = tbl[i].raw;
            light = tbl[i].light;
            tick();
            check($sformatf("lat_clean_e%0d", i + 1), 32'(if_a.sensor_clean), 32'(tbl[i].clean));
            check($sformatf("lat_count_e%0d", i + 1), 32'(if_a.vehicle_count), 32'(tbl[i].cnt));
            check($sformatf("lat_C_e%0d", i + 1), 32'(if_a.C), 32'(tbl[i].c));
        end

        // Glitch of 3 synchronised cycles.
        raw = 1'b0; light = 3'b100;
        do_reset();
        ticks(3);
        raw = 1'b1;
        ticks(3);
        raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch_clean", 32'(if_a.sensor_clean | if_b.sensor_clean), 32'd0);
            check("glitch_count", 32'(if_a.vehicle_count) + 32'(if_b.vehicle_count), 32'd0);
            check("glitch_C", 32'(if_a.C | if_b.C), 32'd0);
        end

        // Single arrival, THRESH=2: timer forces request 20 edges after WAITING entry (edge 7).
        raw = 1'b1; light = 3'b100;
        do_reset();
        ticks(26);
        check("timer_C_before", 32'(if_b.C), 32'd0);
        tick();
        check("timer_C_at_20", 32'(if_b.C), 32'd1);
        check("timer_count", 32'(if_b.vehicle_count), 32'd1);

        // Second arrival reaches threshold before the timer.
        raw = 1'b1; light = 3'b100;
        do_reset();
        ticks(7);
        raw = 1'b0;
        guard = 0;
        while (m[1].clean == 1 && guard < 40) begin tick(); guard++; end
        raw = 1'b1;
        guard = 0;
        while (m[1].cnt != 2 && guard < 40) begin tick(); guard++; end
        check("thresh_reached", 32'(if_b.vehicle_count), 32'd2);
        check("thresh_C_pre", 32'(if_b.C), 32'd0);
        tick();
        check("thresh_C_post", 32'(if_b.C), 32'd1);

        // Grant, arrivals during green and yellow, then red.
        raw = 1'b1; light = 3'b100;
        do_reset();
        ticks(27);
        check("grant_req_a", 32'(if_a.C), 32'd1);
        check("grant_req_b", 32'(if_b.C), 32'd1);
        light = 3'b001;
        tick();
        check("grant_C", 32'(if_a.C | if_b.C), 32'd0);
        check("grant_count", 32'(if_a.vehicle_count) + 32'(if_b.vehicle_count), 32'd0);
        make_arrival();
        check("green_arrival_count", 32'(if_a.vehicle_count) + 32'(if_b.vehicle_count), 32'd0);
        light = 3'b010;
        make_arrival();
        check("yellow_arrival_a", 32'(if_a.vehicle_count), 32'd1);
        check("yellow_arrival_b", 32'(if_b.vehicle_count), 32'd1);
        light = 3'b100;
        tick();
        check("red_C_b", 32'(if_b.C), 32'd0);
        ticks(19);
        check("rewait_C_b_pre", 32'(if_b.C), 32'd0);
        check("rewait_C_a", 32'(if_a.C), 32'd1);
        tick();
        check("rewait_C_b_at_20", 32'(if_b.C), 32'd1);

        // Saturation with CNT_W=2.
        raw = 1'b0; light = 3'b100;
        do_reset();
        for (int i = 0; i < 4; i++) make_arrival();
        check("sat_count_b", 32'(if_b.vehicle_count), 32'd3);
        check("sat_ovf_b", 32'(if_b.overflow), 32'd1);
        check("sat_count_a", 32'(if_a.vehicle_count), 32'd4);
        check("sat_ovf_a", 32'(if_a.overflow), 32'd0);
        light = 3'b001; tick();
        light = 3'b010; tick();
        light = 3'b100; ticks(2);
        check("sat_ovf_sticky", 32'(if_b.overflow), 32'd1);

        // Reset mid-REQUEST.
        raw = 1'b0; light = 3'b100;
        do_reset();
        make_arrival();
        make_arrival();
        tick();
        check("midreq_C", 32'(if_b.C), 32'd1);
        check("midreq_count", 32'(if_b.vehicle_count), 32'd2);
        raw = 1'b0;
        do_reset();
        ticks(30);
        check("post_rst_C", 32'(if_a.C | if_b.C), 32'd0);
        check("post_rst_count", 32'(if_a.vehicle_count) + 32'(if_b.vehicle_count), 32'd0);

        // Random traffic against the model.
        raw = 1'b0; light = 3'b100;
        do_reset();
        hold_raw = 0;
        hold_light = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_raw == 0) begin
                raw = 1'($urandom_range(0, 1));
                hold_raw = $urandom_range(1, 9);
            end
            if (hold_light == 0) begin
                light = lights[$urandom_range(0, 5)];
                hold_light = $urandom_range(5, 40);
            end
            hold_raw--;
            hold_light--;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
